unified_mem_arbiter: RTL and testbench

Arbitrates a single-port synchronous word RAM between the CPU instruction-fetch port and the load/store data port, so one memory array replaces the separate instruction and data memories. Requesters use a req/gnt handshake with a fixed 1-cycle read response. The arbiter sustains one access per cycle. Data has fixed priority over fetch, with a starvation guard for fetch. Sits between the core's fetch/LSU logic and the RAM macro.

---
 rtl/unified_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port 32-bit word RAM between instruction fetch and load/store ports.
// Optional performance counters are enabled by defining MEM_ARB_PERF_EN.
module unified_mem_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int MAX_STARVE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [3:0]        d_wstrb,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
`ifdef MEM_ARB_PERF_EN
   output logic [31:0]       perf_if_gnt,
   output logic [31:0]       perf_d_gnt,
   output logic [31:0]       perf_if_stall,
`endif
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

   logic [3:0]        r_starve_cnt;
   logic              r_rsp_valid;
   logic              r_rsp_owner_d;
   logic              r_rsp_read;
   logic              r_rsp_err;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;

   logic              w_if_oor;
   logic              w_d_oor;
   logic              w_starved;
   logic              w_sel_if;
   logic              w_sel_d;
   logic              w_gnt_any;
   logic              w_win_oor;
   logic [ADDR_W-1:0] w_win_addr;
   logic [31:0]       w_rsp_rdata;
   logic              w_unused_bits;

   // Byte offset bits carry no meaning for a word-wide RAM.
   assign w_unused_bits = ^{if_addr[1:0], d_addr[1:0]};

   assign w_if_oor = |if_addr[31:ADDR_W+2];
   assign w_d_oor  = |d_addr[31:ADDR_W+2];

   assign w_starved = if_req && (r_starve_cnt == STARVE_LIMIT);
   assign w_sel_if  = if_req && (w_starved || !d_req);
   assign w_sel_d   = d_req && !w_starved;

   // Grants are suppressed while reset is held so nothing leaks into the RAM.
   assign if_gnt    = w_sel_if && !reset;
   assign d_gnt     = w_sel_d && !reset;
   assign w_gnt_any = if_gnt || d_gnt;

   assign w_win_oor  = d_gnt ? w_d_oor : w_if_oor;
   assign w_win_addr = d_gnt ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 4'b0000;
      mem_addr  = r_mem_addr;
      mem_wdata = r_mem_wdata;
      if (w_gnt_any) begin
         mem_en    = !w_win_oor;
         mem_addr  = w_win_addr;
         mem_wdata = d_wdata;
         if (d_gnt && d_we && !w_d_oor) begin
            mem_we = d_wstrb;
         end
      end
   end

   // Address/data hold registers keep the RAM pins quiet between accesses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else if (w_gnt_any) begin
         r_mem_addr  <= w_win_addr;
         r_mem_wdata <= d_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_starve_cnt <= 4'd0;
      end else if (if_req && !if_gnt) begin
         if (r_starve_cnt != STARVE_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
         end
      end else begin
         r_starve_cnt <= 4'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rsp_valid   <= 1'b0;
         r_rsp_owner_d <= 1'b0;
         r_rsp_read    <= 1'b0;
         r_rsp_err     <= 1'b0;
      end else begin
         r_rsp_valid <= w_gnt_any;
         if (w_gnt_any) begin
            r_rsp_owner_d <= d_gnt;
            r_rsp_read    <= if_gnt || !d_we;
            r_rsp_err     <= w_win_oor;
         end
      end
   end

   assign w_rsp_rdata = (r_rsp_valid && r_rsp_read && !r_rsp_err) ? mem_rdata : 32'd0;

   assign if_rvalid = r_rsp_valid && !r_rsp_owner_d;
   assign d_rvalid  = r_rsp_valid && r_rsp_owner_d;
   assign if_rdata  = if_rvalid ? w_rsp_rdata : 32'd0;
   assign d_rdata   = d_rvalid ? w_rsp_rdata : 32'd0;
   assign if_err    = if_rvalid && r_rsp_err;
   assign d_err     = d_rvalid && r_rsp_err;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] r_perf_if_gnt;
   logic [31:0] r_perf_d_gnt;
   logic [31:0] r_perf_if_stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_perf_if_gnt   <= 32'd0;
         r_perf_d_gnt    <= 32'd0;
         r_perf_if_stall <= 32'd0;
      end else begin
         if (if_gnt) r_perf_if_gnt <= r_perf_if_gnt + 32'd1;
         if (d_gnt) r_perf_d_gnt <= r_perf_d_gnt + 32'd1;
         if (if_req && !if_gnt) r_perf_if_stall <= r_perf_if_stall + 32'd1;
      end
   end

   assign perf_if_gnt   = r_perf_if_gnt;
   assign perf_d_gnt    = r_perf_d_gnt;
   assign perf_if_stall = r_perf_if_stall;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: behavioural RAM, shadow memory scoreboard, vector table.
module tb_unified_mem_arbiter;
   localparam int ADDR_W = 8;
   localparam int MAX_STARVE = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic [3:0] d_wstrb = '0;
   logic if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_en;
   logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
   logic [3:0] mem_we;
   logic [ADDR_W-1:0] mem_addr;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_if_gnt, perf_d_gnt, perf_if_stall;
`endif

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_STARVE(MAX_STARVE)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
`ifdef MEM_ARB_PERF_EN
      .perf_if_gnt(perf_if_gnt), .perf_d_gnt(perf_d_gnt), .perf_if_stall(perf_if_stall),
`endif
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Read-first RAM macro model.
   logic [31:0] ram [0:(1<<ADDR_W)-1];
   logic [31:0] sh  [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= ram[mem_addr];
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   typedef struct {
      logic ir; logic [31:0] ia;
      logic dr; logic dw; logic [31:0] da; logic [31:0] dwd; logic [3:0] ds;
      logic eig; logic edg;
   } vec_t;

   typedef struct { logic own_d; logic [31:0] rdata; logic err; } rsp_t;

   rsp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                               input logic [3:0] ds, input logic eig, input logic edg);
      vec_t v;
      v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.ds = ds;
      v.eig = eig; v.edg = edg;
      return v;
   endfunction

   function automatic logic oor(input logic [31:0] a);
      return a[31:ADDR_W+2] != '0;
   endfunction

   task automatic check_rsp();
      rsp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, !e.own_d});
         chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, e.own_d});
         if (e.own_d) begin
            chk("d_rdata", d_rdata, e.rdata);
            chk("d_err", {31'd0, d_err}, {31'd0, e.err});
         end else begin
            chk("if_rdata", if_rdata, e.rdata);
            chk("if_err", {31'd0, if_err}, {31'd0, e.err});
         end
      end else begin
         chk("rvalid_idle", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      end
   endtask

   // One bus cycle: check last response, drive v, check grant and RAM pins, queue response.
   task automatic cycle(input vec_t v);
      rsp_t e;
      logic [31:0] a;
      logic bad, st;
      logic [3:0] we_exp;
      @(negedge clk);
      check_rsp();
      if_req = v.ir; if_addr = v.ia;
      d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dwd; d_wstrb = v.ds;
      #1;
      chk("if_gnt", {31'd0, if_gnt}, {31'd0, v.eig});
      chk("d_gnt", {31'd0, d_gnt}, {31'd0, v.edg});
      a = v.edg ? v.da : v.ia;
      bad = oor(a);
      st = v.edg && v.dw;
      we_exp = (st && !bad) ? v.ds : 4'd0;
      chk("mem_en", {31'd0, mem_en}, {31'd0, (v.eig || v.edg) && !bad});
      chk("mem_we", {28'd0, mem_we}, {28'd0, we_exp});
      if ((v.eig || v.edg) && !bad) chk("mem_addr", {24'd0, mem_addr}, {24'd0, a[9:2]});
      if (v.eig || v.edg) begin
         e.own_d = v.edg;
         e.err = bad;
         e.rdata = (st || bad) ? 32'd0 : sh[a[9:2]];
         if (st && !bad)
            for (int b = 0; b < 4; b++)
               if (v.ds[b]) sh[a[9:2]][8*b +: 8] = v.dwd[8*b +: 8];
         exp_q.push_back(e);
      end
      $display("cyc t=%0t ir=%0d ia=%h dr=%0d we=%0d da=%h ig=%0d dg=%0d en=%0d",
               $time, v.ir, v.ia, v.dr, v.dw, v.da, if_gnt, d_gnt, mem_en);
   endtask

   vec_t tbl [14];
   vec_t idle;

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         ram[i] = 32'h1000_0000 + i;
      end
      ram[3] = 32'hDEADBEEF;
      ram[4] = 32'hAABBCCDD;
      for (int i = 0; i < (1 << ADDR_W); i++) sh[i] = ram[i];
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

      //           ir  ia            dr dw da            wdata          strb    eig edg
      tbl[0]  = mk(1, 32'h0000000C, 0, 0, 32'h0,        32'h0,         4'h0,   1, 0);
      tbl[1]  = mk(0, 32'h0,        1, 1, 32'h00000010, 32'h11223344,  4'b0011, 0, 1);
      tbl[2]  = mk(0, 32'h0,        1, 0, 32'h00000010, 32'h0,         4'h0,   0, 1);
      tbl[3]  = mk(0, 32'h0,        0, 0, 32'h0,        32'h0,         4'h0,   0, 0);
      tbl[4]  = mk(1, 32'h00000010, 0, 0, 32'h0,        32'h0,         4'h0,   1, 0);
      tbl[5]  = mk(1, 32'h00000020, 1, 1, 32'h00000020, 32'hCAFEF00D,  4'hF,   0, 1);
      tbl[6]  = mk(1, 32'h00000020, 0, 0, 32'h0,        32'h0,         4'h0,   1, 0);
      tbl[7]  = mk(0, 32'h0,        1, 0, 32'h00000400, 32'h0,         4'h0,   0, 1);
      tbl[8]  = mk(1, 32'h80000000, 0, 0, 32'h0,        32'h0,         4'h0,   1, 0);
      tbl[9]  = mk(0, 32'h0,        1, 1, 32'h00000404, 32'h99999999,  4'hF,   0, 1);
      tbl[10] = mk(0, 32'h0,        1, 0, 32'h00000004, 32'h0,         4'h0,   0, 1);
      tbl[11] = mk(0, 32'h0,        1, 1, 32'h0000000C, 32'h55000000,  4'b1000, 0, 1);
      tbl[12] = mk(1, 32'h0000000E, 0, 0, 32'h0,        32'h0,         4'h0,   1, 0);
      tbl[13] = mk(0, 32'h0,        1, 0, 32'h00000013, 32'h0,         4'h0,   0, 1);

      repeat (2) @(negedge clk);
      chk("rst_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
      chk("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      chk("rst_mem", {27'd0, mem_en, mem_we}, 32'd0);
      reset = 1'b0;

      // Both ports held: data wins four times, then the starved fetch gets one grant.
      for (int k = 1; k <= 10; k++) begin
         cycle(mk(1, 32'h0000000C, 1, 0, 32'h00000014, 32'h0, 4'h0,
                  (k % 5) == 0, (k % 5) != 0));
      end
`ifdef MEM_ARB_PERF_EN
      @(posedge clk); #1;
      chk("perf_d_gnt", perf_d_gnt, 32'd8);
      chk("perf_if_gnt", perf_if_gnt, 32'd2);
      chk("perf_if_stall", perf_if_stall, 32'd8);
`endif

      for (int i = 0; i < 14; i++) cycle(tbl[i]);
      cycle(idle);

      // Reset lands in the response cycle of a fetch grant.
      cycle(mk(1, 32'h0000000C, 0, 0, 32'h0, 32'hFFFF0000, 4'h0, 1, 0));
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("rst_if_gnt_held", {31'd0, if_gnt}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      if_req = 1'b0; d_wdata = 32'hFFFF0000;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(mk(0, 0, 0, 0, 0, 32'hFFFF0000, 0, 0, 0));
         chk("post_rst_mem_addr", {24'd0, mem_addr}, 32'd0);
         chk("post_rst_mem_wdata", mem_wdata, 32'd0);
         chk("post_rst_err", {30'd0, if_err, d_err}, 32'd0);
      end
      @(negedge clk);
      check_rsp();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
